// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte handshake and error pulses between uart_rx and its consumer
// Signals: data/valid/ready byte handshake; frame_err, parity_err, overrun one-cycle pulses.
// master = receiver (drives byte and pulses), slave = consumer (drives ready).
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    modport master (output data, valid, frame_err, parity_err, overrun, input ready);
    modport slave  (input data, valid, frame_err, parity_err, overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 (optionally 8E1) UART receiver with ready/valid byte output and error pulses
// Ports: clk; rst (async, active-high); rxd serial line, idle high;
//        bus (uart_rx_if.master): data/valid held until ready, frame_err/parity_err/overrun pulses.
// Parameter CLKS_PER_BIT (4..65535). Define UART_RX_PARITY_EN to receive an even-parity bit after bit 7.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
    state_t state, state_n;
    logic rx1, rxs;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bcnt, bcnt_n;
    logic [7:0] sr, sr_n;
    logic good, bad, tick;
`ifdef UART_RX_PARITY_EN
    logic perr, perr_n;
`endif
    // cnt counts down to the next sample point and is reloaded there, so it never wraps mid-bit
    assign tick = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n = tick ? cnt : cnt - CW'(1);
        bcnt_n = bcnt;
        sr_n = sr;
        good = 1'b0;
        bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n = perr;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    cnt_n = HALF;
                end
            end
            START: begin
                if (tick) begin
                    state_n = rxs ? IDLE : DATA;
                    cnt_n = rxs ? cnt : FULL;
                    bcnt_n = '0;
`ifdef UART_RX_PARITY_EN
                    perr_n = 1'b0;
`endif
                end
            end
            DATA: begin
                if (tick) begin
                    sr_n = {rxs, sr[7:1]};
                    cnt_n = FULL;
                    bcnt_n = bcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bcnt == 3'd7) state_n = PARITY;
`else
                    if (bcnt == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    perr_n = ^{sr, rxs};
                    cnt_n = FULL;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    good = rxs;
                    bad = !rxs;
                    state_n = rxs ? IDLE : BREAK;
                end
            end
            BREAK: state_n = rxs ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx1 <= 1'b1;
            rxs <= 1'b1;
            cnt <= '0;
            bcnt <= '0;
            sr <= '0;
            bus.data <= '0;
            bus.valid <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            rx1 <= rxd;
            rxs <= rx1;
            cnt <= cnt_n;
            bcnt <= bcnt_n;
            sr <= sr_n;
            bus.frame_err <= bad;
            bus.overrun <= good && bus.valid && !bus.ready;
            // a byte completing in the acceptance cycle replaces the accepted one
            if (good && (!bus.valid || bus.ready)) begin
                bus.data <= sr;
                bus.valid <= 1'b1;
            end else if (bus.ready) begin
                bus.valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr <= 1'b0;
            bus.parity_err <= 1'b0;
        end else begin
            perr <= perr_n;
            bus.parity_err <= good && perr;
        end
    end
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high; clears all state immediately on assertion.
REQ-004 rxd  input  1  asynchronous serial line; idle high.
REQ-005 data  output  8  received byte; valid only while valid is high.
REQ-006 valid  output  1  byte available; held until accepted.
REQ-007 ready  input  1  consumer accepts byte on a cycle where valid and ready are both high.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).
REQ-010 overrun  output  1  one-cycle pulse: a good byte completed while valid was still high.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the second-flop output (rxs).
REQ-012 Frame: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-014 IDLE -> START on rxs == 0; bit counter loaded so the next sample falls CLKS_PER_BIT/2 (integer division) cycles later.
REQ-015 START: at mid-bit sample, rxs == 1 -> IDLE (glitch rejected, no outputs); rxs == 0 -> DATA.
REQ-016 DATA: sample every CLKS_PER_BIT cycles; shift into bit 7 of the shift register; after the 8th sample -> PARITY if enabled, else STOP.
REQ-017 STOP: sample rxs == 1 -> deliver byte per REQ-018..020, then IDLE; rxs == 0 -> frame_err pulse, byte discarded, -> BREAK.
REQ-018 Good byte with valid low: data <= shift register, valid <= 1 in the cycle after the stop sample.
REQ-019 Good byte with valid high and ready low: overrun pulse, new byte discarded, data and valid unchanged.
REQ-020 Good byte in the same cycle as acceptance (valid & ready): acceptance takes priority, new byte loaded, valid stays 1, no overrun.
REQ-021 Acceptance alone SHALL clear valid on the next edge; data holds its last value.
REQ-022 BREAK: wait until rxs == 1, then IDLE; no start detection while in BREAK.
REQ-023 Bit counter width SHALL be ceil(log2(CLKS_PER_BIT)) bits and SHALL never wrap mid-bit.
REQ-024 A parity error SHALL NOT stop stop-bit checking; on a good stop bit the byte is still delivered, with parity_err pulsed in the same cycle valid rises.

Reset
REQ-025 On rst: state = IDLE, both synchronizer flops = 1, data = 8'h00, valid = 0, frame_err = parity_err = overrun = 0, counters = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no error pulses; reception resumes with the first falling edge after release.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state present; one even-parity bit sampled after bit 7; mismatch -> parity_err per REQ-024.
REQ-028 Macro UART_RX_PARITY_EN undefined: PARITY state and its logic absent; DATA -> STOP directly; parity_err tied 0; port list unchanged.

Verification
REQ-029 CLKS_PER_BIT=16, no parity, ready=1, send 8'hA5 -> valid high 1 cycle, data=8'hA5, no error pulses.
REQ-030 rxd low for 6 cycles then high, idle -> state returns to IDLE, valid/frame_err stay 0.
REQ-031 Send 8'h3C with stop bit 0, then line held low 40 cycles -> frame_err 1 pulse, valid 0, no new frame until rxd high; then 8'h81 -> data=8'h81.
REQ-032 ready=0, send 8'h11 then 8'h22 -> valid held, data=8'h11, overrun 1 pulse at the end of the second frame.
REQ-033 UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 (wrong) -> valid, data=8'h07, parity_err pulse in the same cycle; correct parity bit 1 -> no pulse.
REQ-034 rst pulsed during data bit 4 of 8'hFF -> all outputs reset values, no pulses; next frame 8'h5A received correctly.
